// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory for the fetch stage. Requests use a valid/ready handshake,
// and responses return through a 2-entry buffer. Includes a program-load port and fault flags.
module instr_fetch_mem #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 1024,
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instr,
  output logic [1:0]        resp_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [31:0]       fetch_count
);

  localparam int unsigned       OFFS     = $clog2(DATA_W / 8);
  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFFS) - 64'd1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  // bit1: word index past the end of the array, bit0: low byte-offset bits nonzero
  function automatic logic [1:0] fault_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = a >> OFFS;
    return {idx >= DEPTH_A, (a & OFF_MASK) != '0};
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] req_idx, load_idx;
  logic [1:0]        req_flt, load_flt;
  logic [DATA_W-1:0] req_word;
  logic [1:0]        count;
  logic [DATA_W-1:0] e_instr [2];
  logic [1:0]        e_fault [2];
  logic [31:0]       fetch_cnt;
  logic              accept, pop;

  always_comb begin
    req_idx  = req_addr >> OFFS;
    load_idx = load_addr >> OFFS;
    req_flt  = fault_of(req_addr);
    load_flt = fault_of(load_addr);
    req_word = NOP_INSTR;
    if (req_flt == 2'b00) req_word = mem[req_idx[IDX_W-1:0]];
  end

  assign req_ready   = !flush && (count != 2'd2);
  assign resp_valid  = (count != 2'd0);
  assign resp_instr  = e_instr[0];
  assign resp_fault  = e_fault[0];
  assign fetch_count = fetch_cnt;
  assign accept      = req_valid && req_ready;
  assign pop         = resp_valid && resp_ready && !flush;

  // Fetch lookup above samples the array before this write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (load_en && (load_flt == 2'b00)) mem[load_idx[IDX_W-1:0]] <= load_data;
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      e_instr[0] <= '0;
      e_instr[1] <= '0;
      e_fault[0] <= '0;
      e_fault[1] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e_instr[0] <= req_word;
            e_fault[0] <= req_flt;
          end else begin
            e_instr[1] <= req_word;
            e_fault[1] <= req_flt;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          e_instr[0] <= e_instr[1];
          e_fault[0] <= e_fault[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e_instr[0] <= req_word;
            e_fault[0] <= req_flt;
          end else begin
            e_instr[0] <= e_instr[1];
            e_fault[0] <= e_fault[1];
            e_instr[1] <= req_word;
            e_fault[1] <= req_flt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fetch_cnt <= '0;
    else if (accept && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: a bench-side model pushes expected responses
// on every accept and compares them against the buffer head while it is valid.
module tb_instr_fetch_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_addr, resp_instr, load_addr, load_data, fetch_count;
  logic [1:0]  resp_fault;
  logic        flush, load_en;

  instr_fetch_mem #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_fault(resp_fault),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [33:0] sb [$];
  logic [31:0] mmem [int unsigned];
  logic [31:0] fc_model = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] model_fault(input logic [31:0] a);
    return {(a >> 2) >= 32'd1024, a[1:0] != 2'b00};
  endfunction

  // Called just after a falling edge with inputs driven; advances to the next falling edge.
  task automatic cycle();
    logic        exp_rdy;
    logic [1:0]  f;
    logic [31:0] w;
    #1;
    exp_rdy = !flush && (sb.size() != 2);
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("resp_valid", 64'(resp_valid), 64'(sb.size() != 0));
    check_eq("fetch_count", 64'(fetch_count), 64'(fc_model));
    if (sb.size() != 0) begin
      check_eq("resp_instr", 64'(resp_instr), 64'(sb[0][31:0]));
      check_eq("resp_fault", 64'(resp_fault), 64'(sb[0][33:32]));
      if (resp_ready && !flush) void'(sb.pop_front());
    end
    if (flush) sb.delete();
    if (req_valid && exp_rdy) begin
      f = model_fault(req_addr);
      w = (f == 2'b00) ? mmem[req_addr >> 2] : NOP;
      sb.push_back({f, w});
      if (fc_model != 32'hFFFF_FFFF) fc_model++;
    end
    if (load_en && model_fault(load_addr) == 2'b00) mmem[load_addr >> 2] = load_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rv, input logic [31:0] a, input logic rr, input logic fl,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
    req_valid = rv; req_addr = a; resp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    cycle();
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    drive(1'b1, a, rr, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clk);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_instr", 64'(resp_instr), 64'd0);
    check_eq("rst_resp_fault", 64'(resp_fault), 64'd0);
    check_eq("rst_fetch_count", 64'(fetch_count), 64'd0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 4; i++)
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'(i * 4), 32'h1111_1111 * 32'(i + 1));

    for (int unsigned i = 0; i < 4; i++) fetch(32'(i * 4), 1'b1);
    idle(2);
    check_eq("count_after_4", 64'(fetch_count), 64'd4);

    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    fetch(32'h8, 1'b0);
    fetch(32'h8, 1'b0);
    fetch(32'h8, 1'b1);
    fetch(32'h8, 1'b1);
    idle(3);

    fetch(32'h2, 1'b1);
    fetch(32'h1000, 1'b1);
    fetch(32'h1002, 1'b1);
    idle(2);

    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, '0, '0);
    fetch(32'hC, 1'b1);
    idle(2);

    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4, 32'h5555_5555);
    fetch(32'h4, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h6, 32'h6666_6666);
    fetch(32'h4, 1'b1);
    fetch(32'h8, 1'b1);
    idle(2);

    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("midrst_resp_instr", 64'(resp_instr), 64'd0);
    check_eq("midrst_resp_fault", 64'(resp_fault), 64'd0);
    check_eq("midrst_fetch_count", 64'(fetch_count), 64'd0);
    sb.delete();
    fc_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h0, 1'b1);
    idle(2);

    force dut.fetch_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_cnt;
    fc_model = 32'hFFFF_FFFE;
    fetch(32'h8, 1'b1);
    fetch(32'hC, 1'b1);
    fetch(32'h0, 1'b1);
    idle(2);
    check_eq("fetch_count_sat", 64'(fetch_count), 64'h0000_0000_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
